// File: rtl/evm_pkg.sv
// Shared constants and types for the EVM tally reporting path.
package evm_pkg;

    localparam logic [7:0]  TALLY_HDR    = 8'hA5;
    localparam int unsigned TALLY_NBYTES = 6;
    localparam int unsigned TALLY_CNT_W  = 6;

    localparam logic [1:0] CAND_ID_1 = 2'd0;
    localparam logic [1:0] CAND_ID_2 = 2'd1;
    localparam logic [1:0] CAND_ID_3 = 2'd2;
    localparam logic [1:0] CAND_ID_4 = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tally_state_e;

    // Payload byte: candidate id in the top two bits, count below.
    function automatic logic [7:0] tally_byte(input logic [1:0] id,
                                              input logic [TALLY_CNT_W-1:0] cnt);
        return {id, cnt};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; a start request during the last stop-bit cycle chains
// the next byte with no idle gap.
module uart_tx_byte
    import evm_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       byte_end_c
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tally_state_e      r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [7:0]        r_shreg;
    logic              w_baud_last;
    logic              w_load;

    assign w_baud_last = (r_baud == BAUD_LAST);
    assign byte_end_c  = (r_state == STOP) && w_baud_last;
    assign w_load      = start && ((r_state == IDLE) || byte_end_c);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_load) begin
                r_state <= START;
                r_shreg <= data_in;
                r_baud  <= '0;
                r_bit   <= '0;
                tx      <= 1'b0;
                busy    <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_baud <= '0;
                    end
                    START: begin
                        if (w_baud_last) begin
                            r_baud  <= '0;
                            r_state <= DATA;
                            tx      <= r_shreg[0];
                        end else begin
                            r_baud <= r_baud + BAUD_W'(1);
                        end
                    end
                    DATA: begin
                        if (w_baud_last) begin
                            r_baud <= '0;
                            if (r_bit == 3'd7) begin
                                r_bit   <= '0;
                                r_state <= STOP;
                                tx      <= 1'b1;
                            end else begin
                                r_bit   <= r_bit + 3'd1;
                                r_shreg <= {1'b0, r_shreg[7:1]};
                                tx      <= r_shreg[1];
                            end
                        end else begin
                            r_baud <= r_baud + BAUD_W'(1);
                        end
                    end
                    STOP: begin
                        if (w_baud_last) begin
                            r_baud  <= '0;
                            r_state <= IDLE;
                            tx      <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_baud <= r_baud + BAUD_W'(1);
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        tx      <= 1'b1;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/tally_uart_tx.sv
// Snapshots the four vote counts on a result-mode request and sends them as
// a 6-byte framed packet (header, four id/count bytes, XOR checksum).
module tally_uart_tx
    import evm_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned COUNT_W      = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               mode,
    input  logic               report_req,
    input  logic [COUNT_W-1:0] candidate1_votes,
    input  logic [COUNT_W-1:0] candidate2_votes,
    input  logic [COUNT_W-1:0] candidate3_votes,
    input  logic [COUNT_W-1:0] candidate4_votes,
    output logic               tx,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] IDX_LAST = 3'(TALLY_NBYTES - 1);

    logic [COUNT_W-1:0] r_snap1, r_snap2, r_snap3, r_snap4;
    logic [2:0]         r_byte_idx;

    logic       w_tx, w_busy, w_done, w_byte_end;
    logic       w_accept, w_next, w_start;
    logic [7:0] w_b1, w_b2, w_b3, w_b4, w_chk;
    logic [7:0] w_next_byte, w_data;

    assign w_accept = !w_busy && mode && report_req;
    assign w_next   = w_byte_end && (r_byte_idx < IDX_LAST);
    assign w_start  = w_accept || w_next;

    assign w_b1  = tally_byte(CAND_ID_1, TALLY_CNT_W'(r_snap1));
    assign w_b2  = tally_byte(CAND_ID_2, TALLY_CNT_W'(r_snap2));
    assign w_b3  = tally_byte(CAND_ID_3, TALLY_CNT_W'(r_snap3));
    assign w_b4  = tally_byte(CAND_ID_4, TALLY_CNT_W'(r_snap4));
    assign w_chk = w_b1 ^ w_b2 ^ w_b3 ^ w_b4;

    // Byte following the one currently on the line.
    always_comb begin
        w_next_byte = w_chk;
        case (r_byte_idx)
            3'd0:    w_next_byte = w_b1;
            3'd1:    w_next_byte = w_b2;
            3'd2:    w_next_byte = w_b3;
            3'd3:    w_next_byte = w_b4;
            default: w_next_byte = w_chk;
        endcase
    end

    assign w_data = w_accept ? TALLY_HDR : w_next_byte;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_snap1    <= '0;
            r_snap2    <= '0;
            r_snap3    <= '0;
            r_snap4    <= '0;
            r_byte_idx <= '0;
        end else if (w_accept) begin
            r_snap1    <= candidate1_votes;
            r_snap2    <= candidate2_votes;
            r_snap3    <= candidate3_votes;
            r_snap4    <= candidate4_votes;
            r_byte_idx <= '0;
        end else if (w_next) begin
            r_byte_idx <= r_byte_idx + 3'd1;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clock      (clock),
        .reset      (reset),
        .start      (w_start),
        .data_in    (w_data),
        .tx         (w_tx),
        .busy       (w_busy),
        .done       (w_done),
        .byte_end_c (w_byte_end)
    );

    assign tx   = w_tx;
    assign busy = w_busy;
    assign done = w_done;

endmodule

// File: tb/tb_tally_uart_tx.sv
// Scoreboard bench for tally_uart_tx: expected bytes queued at request time,
// popped as the line monitor decodes each 8N1 frame.
module tb_tally_uart_tx;

    localparam int unsigned CPB = 4;
    localparam int unsigned CW  = 4;

    logic          clk, rst_n, mode, report_req;
    logic [CW-1:0] c1, c2, c3, c4;
    logic          tx, busy, done;

    int         n_checks = 0;
    int         n_errors = 0;
    int         mon_bytes = 0;
    int         mon_off = 0;
    logic       mon_act = 1'b0;
    logic [7:0] mon_sh = '0;
    logic [7:0] exp_q[$];

    tally_uart_tx #(.CLKS_PER_BIT(CPB), .COUNT_W(CW)) dut (
        .clock            (clk),
        .reset            (rst_n),
        .mode             (mode),
        .report_req       (report_req),
        .candidate1_votes (c1),
        .candidate2_votes (c2),
        .candidate3_votes (c3),
        .candidate4_votes (c4),
        .tx               (tx),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line monitor: offset 0 is the first low sample of a start bit.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act = 1'b0;
            mon_off = 0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act = 1'b1;
                mon_off = 0;
            end
        end else begin
            mon_off++;
            if (mon_off == 1) begin
                check("start_bit", 32'(tx), 32'd0);
            end else if (mon_off >= 5 && mon_off <= 33 && ((mon_off - 5) % 4) == 0) begin
                mon_sh[(mon_off - 5) / 4] = tx;
            end else if (mon_off == 37) begin
                check("stop_bit", 32'(tx), 32'd1);
                mon_bytes++;
                if (exp_q.size() == 0)
                    check("extra_byte", 32'(mon_sh), 32'hFFFF_FFFF);
                else
                    check("pkt_byte", 32'(mon_sh), 32'(exp_q.pop_front()));
                mon_act = 1'b0;
            end
        end
    end

    task automatic push_packet(input logic [CW-1:0] a, input logic [CW-1:0] b,
                               input logic [CW-1:0] c, input logic [CW-1:0] d);
        logic [7:0] bt [6];
        bt[0] = 8'hA5;
        bt[1] = {2'd0, 6'(a)};
        bt[2] = {2'd1, 6'(b)};
        bt[3] = {2'd2, 6'(c)};
        bt[4] = {2'd3, 6'(d)};
        bt[5] = bt[1] ^ bt[2] ^ bt[3] ^ bt[4];
        for (int i = 0; i < 6; i++) exp_q.push_back(bt[i]);
    endtask

    // Called at a negedge; returns at the negedge where done is seen (or after reset).
    task automatic run_packet(input logic [CW-1:0] a, input logic [CW-1:0] b,
                              input logic [CW-1:0] c, input logic [CW-1:0] d,
                              input int change_at, input int rereq_at, input int rst_at);
        int n, busy_cnt, done_cnt, done_at;
        n = 0; busy_cnt = 0; done_cnt = 0; done_at = -1;
        mon_bytes = 0;
        c1 = a; c2 = b; c3 = c; c4 = d;
        report_req = 1'b1;
        push_packet(a, b, c, d);
        @(posedge clk);
        #1;
        report_req = 1'b0;
        check("accept_tx_low", 32'(tx), 32'd0);
        check("accept_busy", 32'(busy), 32'd1);
        while (n < 400 && done_at < 0) begin
            @(negedge clk);
            n++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = n;
            end
            if (change_at > 0 && n == change_at) begin
                c1 = 4'd15;
                mode = 1'b0;
            end
            if (rereq_at > 0 && n == rereq_at) report_req = 1'b1;
            if (rereq_at > 0 && n == rereq_at + 1) report_req = 1'b0;
            if (rst_at > 0 && n == rst_at) begin
                check("tx_before_rst", 32'(tx), 32'd0);
                rst_n = 1'b0;
                #1;
                check("rst_async_tx", 32'(tx), 32'd1);
                check("rst_async_busy", 32'(busy), 32'd0);
                repeat (3) begin
                    @(negedge clk);
                    check("rst_no_done", 32'(done), 32'd0);
                end
                exp_q.delete();
                rst_n = 1'b1;
                return;
            end
        end
        if (done_at < 0) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("done_cycle", 32'(done_at), 32'd241);
            check("busy_cycles", 32'(busy_cnt), 32'd240);
            check("done_pulses", 32'(done_cnt), 32'd1);
            check("busy_at_done", 32'(busy), 32'd0);
            check("tx_idle_at_done", 32'(tx), 32'd1);
            check("bytes_rx", 32'(mon_bytes), 32'd6);
            check("queue_empty", 32'(exp_q.size()), 32'd0);
        end
        mode = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; report_req = 1'b0;
        c1 = '0; c2 = '0; c3 = '0; c4 = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_tx", 32'(tx), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end

        mode = 1'b1;
        run_packet(4'd3, 4'd5, 4'd0, 4'd9, 0, 0, 0);

        mode = 1'b0;
        report_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("vote_mode_tx", 32'(tx), 32'd1);
            check("vote_mode_busy", 32'(busy), 32'd0);
        end
        report_req = 1'b0;
        mode = 1'b1;
        @(negedge clk);

        run_packet(4'd3, 4'd5, 4'd0, 4'd9, 50, 0, 0);
        run_packet(4'd1, 4'd2, 4'd15, 4'd7, 0, 100, 0);
        run_packet(4'd3, 4'd5, 4'd0, 4'd9, 0, 0, 70);
        run_packet(4'd12, 4'd6, 4'd10, 4'd4, 0, 0, 0);
        run_packet(4'd15, 4'd15, 4'd15, 4'd15, 0, 0, 0);
        run_packet(4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 0);
        run_packet(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0, 0, 0);

        repeat (10) begin
            @(negedge clk);
            check("final_idle_busy", 32'(busy), 32'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tally_uart_tx.md
Name: tally_uart_tx

Overview:
- Reads the four candidate vote counters produced by the vote-logging stage and reports them off-chip as a serial UART packet.
- Sits beside mode_control at the top level and is the consumer (reader) side of the vote counters.
- A report request in result mode snapshots all four counts in one cycle, then transmits a 6-byte framed packet with checksum on a single 8N1 line.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Legal range is 2 or more.
- COUNT_W, 4: width of each candidate count. Legal range is 1..6. Counts are zero-extended to 6 bits in the packet.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- mode  input  1  1 = result mode (reporting allowed); 0 = voting mode.
- report_req  input  1  request pulse; level is sampled each cycle.
- candidate1_votes  input  COUNT_W  current count, candidate 1.
- candidate2_votes  input  COUNT_W  current count, candidate 2.
- candidate3_votes  input  COUNT_W  current count, candidate 3.
- candidate4_votes  input  COUNT_W  current count, candidate 4.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high while a packet is in flight.
- done  output  1  one-cycle pulse when the packet completes.

Behaviour:
- Reset (reset=0, asynchronous): tx=1, busy=0, done=0, FSM=IDLE, byte index=0, baud and bit counters=0, snapshot registers=0.
- Accept rule: a request is accepted at a rising edge where FSM=IDLE, mode=1 and report_req=1.
  - At that edge all four counts are snapshotted together, busy goes to 1 and FSM goes to START.
  - report_req is ignored while busy or while mode=0. Requests are not queued.
- Packet bytes, in order:
  - B0 = 8'hA5 (header).
  - B1..B4 = {id[1:0], zero-extended count[5:0]}, with id = 0..3 for candidates 1..4.
  - B5 = XOR of B1..B4.
- Byte framing: 8N1, LSB first. One start bit (0), 8 data bits, one stop bit (1). Every bit lasts exactly CLKS_PER_BIT cycles.
- Timing:
  - tx falls at the accepting edge, i.e. latency 1 cycle from the sampled report_req.
  - Bytes are back-to-back with no idle gap.
  - A packet is 60 bit-times = 60*CLKS_PER_BIT cycles.
- FSM states and transitions:
  - IDLE → START on accept.
  - START → DATA after one bit-time.
  - DATA → STOP after 8 bit-times.
  - STOP → START with next byte index if index < 5.
  - STOP → IDLE with done=1 and busy=0 at the edge ending the stop bit of B5.
- done is high for exactly one cycle. busy falls on the same edge that done rises.
- A new request is accepted at the earliest on the cycle after done.
- Snapshot consistency: count changes during transmission never alter the packet in flight.
- mode falling to 0 mid-packet does not abort; the packet completes normally.
- Reset mid-packet: tx returns to 1 immediately (asynchronously) and the partial frame is abandoned. No done is generated.
- Arithmetic:
  - The bit counter wraps 0..7.
  - The baud counter counts 0..CLKS_PER_BIT-1 and terminal count advances the bit.
  - The byte index counts 0..5 and never wraps mid-packet.

Decomposition:
- Shared package evm_pkg holds:
  - TALLY_HDR = 8'hA5.
  - TALLY_NBYTES = 6.
  - Candidate ID constants 0..3.
  - Packet-level state enum {IDLE, START, DATA, STOP}.
- Natural sub-module uart_tx_byte: a byte serializer with a start/data_in input and busy/done outputs, parameterised by CLKS_PER_BIT.
- tally_uart_tx keeps the snapshot, byte mux, checksum and byte sequencing.

Test Plan (use CLKS_PER_BIT=4):
- Reset, then idle 20 cycles → tx=1, busy=0, done=0 throughout.
- mode=1, counts 3,5,0,9, one-cycle report_req → tx decodes to A5 03 45 80 C9 0F; busy high for 240 cycles; done pulses once at cycle 240 after accept.
- mode=0 with report_req held high for 10 cycles → no start bit, busy stays 0.
- Counts 3,5,0,9 accepted, then count 1 changed to 15 and mode dropped to 0 at cycle 50 → packet is still A5 03 45 80 C9 0F.
- report_req pulsed again at cycle 100 of an active packet → ignored; exactly one packet and one done pulse.
- reset asserted at cycle 70 mid-packet → tx=1 in the same cycle with no clock edge needed, busy=0, no done; a later request sends a complete fresh packet.
